// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the RISC-V core.
// Owns the PC and keeps at most one instruction-memory read in flight over a
// valid/ready channel. The returned word and its PC are held in the if_*
// register for decode. Downstream stalls, redirects and the decoder's halt
// are honoured.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, a
// misaligned redirect target raises the sticky misalign fault and parks fetch
// in HALT. When it is undefined, the low two bits of the target are cleared.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            misalign
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // free to issue the next request
    S_WAIT  = 2'd1,  // one request in flight, its response will be kept
    S_DRAIN = 2'd2,  // one request in flight, its response will be dropped
    S_HALT  = 2'd3   // terminal until reset
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            halt_pend_q, halt_pend_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            misalign_q, misalign_d;
`endif

  logic            halt_eff;
  logic            req_valid;
  logic            req_fire;
  logic            consume;
  logic            outstanding_nxt;
  logic            redir_bad;
  logic [XLEN-1:0] redir_tgt;

  // Halt is only meaningful for the instruction actually sitting in if_*.
  // A redirect in the same cycle means that instruction is on the wrong path.
  assign halt_eff  = halt & if_valid_q & ~redirect_valid;

  // Issue only when the output register is sure to be empty by the time the
  // response arrives. This is why no skid buffer is needed.
  assign req_valid = rst_n & (state_q == S_FETCH) & (~if_valid_q | id_ready)
                   & ~redirect_valid & ~halt_eff;
  assign req_fire  = req_valid & imem_req_ready;
  assign consume   = if_valid_q & id_ready;

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_bad = |redirect_pc[1:0];
  assign redir_tgt = redirect_pc;
  assign misalign  = misalign_q;
`else
  assign redir_bad = 1'b0;
  assign redir_tgt = redirect_pc & ~XLEN'(3);
  assign misalign  = 1'b0;
`endif

  // Whether a request will still be in flight after this cycle; decides if a
  // redirect must first pass through DRAIN to swallow a stale response.
  always_comb begin
    outstanding_nxt = 1'b0;
    case (state_q)
      S_FETCH: outstanding_nxt = req_fire;
      S_WAIT,
      S_DRAIN: outstanding_nxt = ~imem_rsp_valid;
      default: outstanding_nxt = 1'b0;
    endcase
  end

  // Next-state logic: redirect beats drain/halt, halt beats fill.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    halt_pend_d = halt_pend_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif

    if (consume) begin
      if_valid_d = 1'b0;
    end

    if (state_q == S_HALT) begin
      if_valid_d = 1'b0;
    end else if (redirect_valid) begin
      if_valid_d = 1'b0;
      if (redir_bad) begin
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d = 1'b1;
`endif
        halt_pend_d = 1'b1;
        state_d     = outstanding_nxt ? S_DRAIN : S_HALT;
      end else begin
        pc_d        = redir_tgt;
        halt_pend_d = 1'b0;
        state_d     = outstanding_nxt ? S_DRAIN : S_FETCH;
      end
    end else if (state_q == S_DRAIN) begin
      if (imem_rsp_valid) begin
        state_d     = halt_pend_q ? S_HALT : S_FETCH;
        halt_pend_d = halt_pend_q;
      end
    end else if (halt_eff) begin
      if_valid_d = 1'b0;
      if (state_q == S_FETCH) begin
        state_d = S_HALT;
      end else begin
        halt_pend_d = 1'b1;
        state_d     = imem_rsp_valid ? S_HALT : S_DRAIN;
      end
    end else if (state_q == S_FETCH) begin
      if (req_fire) begin
        state_d = S_WAIT;
      end
    end else if (imem_rsp_valid) begin
      if_valid_d = 1'b1;
      if_instr_d = imem_rsp_data;
      if_pc_d    = pc_q;
      pc_d       = pc_q + XLEN'(4);
      state_d    = S_FETCH;
    end
  end

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_instr_q  <= 32'h0;
      if_pc_q     <= '0;
      halt_pend_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      halt_pend_q <= halt_pend_d;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: reset state, streaming fetch, stall,
// redirect with drain, halt, reset mid-request, PC wrap, misaligned redirect.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        misalign;

  int tests;
  int fails;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .misalign       (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, then settle before checking.
  task automatic set_in(input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic idr, input logic redv, input logic [31:0] redpc,
                        input logic hl);
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    id_ready       = idr;
    redirect_valid = redv;
    redirect_pc    = redpc;
    halt           = hl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    set_in(1, 0, 0, 1, 0, 0, 0);
    tick();
    // Reset state
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_if_valid",  if_valid, 1'b0);
    chk("rst_if_instr",  if_instr, 32'h0);
    chk("rst_if_pc",     if_pc, 32'h0);
    chk("rst_misalign",  misalign, 1'b0);
    rst_n = 1'b1;

    // Streaming with 1-cycle memory
    set_in(1, 0, 0, 1, 0, 0, 0);
    chk("c1_req_valid", imem_req_valid, 1'b1);
    chk("c1_req_addr",  imem_req_addr, 32'h0);
    tick();
    set_in(1, 1, 32'hA000_0000, 1, 0, 0, 0);
    chk("c2_req_valid", imem_req_valid, 1'b0);
    chk("c2_if_valid",  if_valid, 1'b0);
    tick();
    set_in(1, 0, 0, 1, 0, 0, 0);
    chk("c3_if_valid",  if_valid, 1'b1);
    chk("c3_if_pc",     if_pc, 32'h0);
    chk("c3_if_instr",  if_instr, 32'hA000_0000);
    chk("c3_req_valid", imem_req_valid, 1'b1);
    chk("c3_req_addr",  imem_req_addr, 32'h4);
    tick();
    set_in(1, 1, 32'hA000_0001, 1, 0, 0, 0);
    chk("c4_if_valid",  if_valid, 1'b0);
    tick();
    set_in(1, 0, 0, 1, 0, 0, 0);
    chk("c5_if_valid",  if_valid, 1'b1);
    chk("c5_if_pc",     if_pc, 32'h4);
    chk("c5_if_instr",  if_instr, 32'hA000_0001);
    chk("c5_req_addr",  imem_req_addr, 32'h8);
    tick();
    set_in(1, 1, 32'hA000_0002, 1, 0, 0, 0);
    tick();

    // Decode stall: if_* held, no issue
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      chk("stall_if_valid",  if_valid, 1'b1);
      chk("stall_if_pc",     if_pc, 32'h8);
      chk("stall_if_instr",  if_instr, 32'hA000_0002);
      chk("stall_req_valid", imem_req_valid, 1'b0);
      tick();
    end
    set_in(1, 0, 0, 1, 0, 0, 0);
    chk("unstall_req_valid", imem_req_valid, 1'b1);
    chk("unstall_req_addr",  imem_req_addr, 32'hC);
    tick();

    // Redirect while a request is outstanding: stale response discarded
    set_in(1, 0, 0, 1, 1, 32'h100, 0);
    chk("redir_req_valid", imem_req_valid, 1'b0);
    tick();
    set_in(1, 0, 0, 1, 0, 0, 0);
    chk("drain_req_valid", imem_req_valid, 1'b0);
    chk("drain_if_valid",  if_valid, 1'b0);
    tick();
    set_in(1, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    chk("drain_rsp_req_valid", imem_req_valid, 1'b0);
    tick();
    set_in(1, 0, 0, 1, 0, 0, 0);
    chk("post_drain_if_valid",  if_valid, 1'b0);
    chk("post_drain_req_valid", imem_req_valid, 1'b1);
    chk("post_drain_req_addr",  imem_req_addr, 32'h100);
    tick();
    set_in(1, 1, 32'hB000_0000, 1, 0, 0, 0);
    tick();

    // Halt and redirect together: redirect wins
    set_in(1, 0, 0, 1, 1, 32'h200, 1);
    chk("hr_if_valid",  if_valid, 1'b1);
    chk("hr_if_pc",     if_pc, 32'h100);
    chk("hr_if_instr",  if_instr, 32'hB000_0000);
    chk("hr_req_valid", imem_req_valid, 1'b0);
    tick();
    set_in(1, 0, 0, 1, 0, 0, 0);
    chk("hr_next_if_valid", if_valid, 1'b0);
    chk("hr_next_req_valid", imem_req_valid, 1'b1);
    chk("hr_next_req_addr",  imem_req_addr, 32'h200);
    tick();
    set_in(1, 1, 32'hB000_0001, 1, 0, 0, 0);
    tick();

    // Halt alone: fetch stops for good
    set_in(1, 0, 0, 1, 0, 0, 1);
    chk("halt_if_valid",  if_valid, 1'b1);
    chk("halt_if_pc",     if_pc, 32'h200);
    chk("halt_req_valid", imem_req_valid, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      set_in(1, i[0], 32'h1111_1111, 1, (i == 5), 32'h300, 1);
      chk("halted_req_valid", imem_req_valid, 1'b0);
      chk("halted_if_valid",  if_valid, 1'b0);
      tick();
    end

    // Reset while in WAIT; response right after release is ignored
    rst_n = 1'b0;
    set_in(1, 0, 0, 1, 0, 0, 0);
    chk("rst2_req_valid", imem_req_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    set_in(1, 0, 0, 1, 0, 0, 0);
    chk("rst2_c1_req_valid", imem_req_valid, 1'b1);
    chk("rst2_c1_req_addr",  imem_req_addr, 32'h0);
    tick();
    rst_n = 1'b0;
    set_in(1, 0, 0, 1, 0, 0, 0);
    chk("rst3_req_valid", imem_req_valid, 1'b0);
    chk("rst3_if_valid",  if_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    set_in(1, 1, 32'hBAD0_BAD0, 1, 0, 0, 0);
    chk("rst3_c1_req_valid", imem_req_valid, 1'b1);
    chk("rst3_c1_req_addr",  imem_req_addr, 32'h0);
    tick();
    set_in(1, 1, 32'hC000_0000, 1, 0, 0, 0);
    chk("rst3_c2_if_valid", if_valid, 1'b0);
    chk("rst3_c2_req_valid", imem_req_valid, 1'b0);
    tick();

    // PC wrap at the top of the address space
    set_in(1, 0, 0, 1, 1, 32'hFFFF_FFFC, 0);
    chk("rst3_fill_if_valid", if_valid, 1'b1);
    chk("rst3_fill_if_pc",    if_pc, 32'h0);
    chk("rst3_fill_if_instr", if_instr, 32'hC000_0000);
    tick();
    set_in(1, 0, 0, 1, 0, 0, 0);
    chk("wrap_req_valid", imem_req_valid, 1'b1);
    chk("wrap_req_addr",  imem_req_addr, 32'hFFFF_FFFC);
    tick();
    set_in(1, 1, 32'hC000_0001, 1, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 1, 0, 0, 0);
    chk("wrap_if_valid",  if_valid, 1'b1);
    chk("wrap_if_pc",     if_pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", imem_req_addr, 32'h0);
    chk("wrap_next_valid", imem_req_valid, 1'b1);
    tick();

    // Misaligned redirect target
    set_in(1, 0, 0, 1, 1, 32'h102, 0);
    chk("mis_req_valid", imem_req_valid, 1'b0);
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 1, 0, 0, 0);
      chk("mis_flag",          misalign, 1'b1);
      chk("mis_halt_req",      imem_req_valid, 1'b0);
      chk("mis_halt_if_valid", if_valid, 1'b0);
      tick();
    end
`else
    set_in(0, 0, 0, 1, 0, 0, 0);
    chk("mis_flag",      misalign, 1'b0);
    chk("mis_if_valid",  if_valid, 1'b0);
    chk("mis_req_valid2", imem_req_valid, 1'b1);
    chk("mis_req_addr",  imem_req_addr, 32'h100);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
